spi_tx_feeder: RTL and testbench
================================

Name: spi_tx_feeder

Overview:
- Upstream byte-feeding stage for the SPI master/peripheral pair (spigen + spiperi).
- Buffers bytes written by a host in a small FIFO and drives the SPI stage's start, p_dat, cpol and cpha inputs.
- Launches one 8-bit frame at a time, then waits a fixed frame time plus an inter-frame gap before launching the next byte.
- The SPI stage exposes no done flag, so frame pacing is by a clk-cycle counter sized to the SPI frame length.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- FRAME_CYCLES, 40: clk cycles one SPI frame occupies after start; must be >= 1.
- GAP_CYCLES, 4: idle clk cycles between end of frame wait and next launch; 0 allowed.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  host write strobe, one byte per cycle
- wr_data  in  8  byte to enqueue
- cfg_cpol  in  1  clock polarity, sampled at frame launch
- cfg_cpha  in  1  clock phase, sampled at frame launch
- flush  in  1  synchronous: empty FIFO, abort pacing
- start  out  1  one-cycle launch pulse to SPI stage
- p_dat  out  8  byte under transmission, held stable between launches
- cpol  out  1  latched polarity for current frame
- cpha  out  1  latched phase for current frame
- busy  out  1  high from launch until gap completes
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- count  out  log2(DEPTH)+1  FIFO occupancy
- ovf  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; FIFO pointers and count clear.
  - start=0, p_dat=8'h00, cpol=0, cpha=0, busy=0, full=0, empty=1, count=0, ovf=0.
- All outputs are registered.

FIFO:
- Circular buffer with wr_ptr and rd_ptr, wrapping at DEPTH-1 -> 0.
- Write is accepted when wr_en=1 and full=0.
- Write with full=1 is dropped, even if a pop occurs the same cycle; ovf pulses for 1 cycle.
- count updates on the cycle after the write/pop edge: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
- full = (count==DEPTH); empty = (count==0).

FSM (IDLE, LAUNCH, WAIT, GAP):
- IDLE: if empty=0, go to LAUNCH at the next edge. At that same edge:
  - pop the head into p_dat;
  - latch cfg_cpol/cfg_cpha into cpol/cpha;
  - set start=1 and busy=1.
- LAUNCH: lasts 1 cycle. Next edge: start=0, load cnt=FRAME_CYCLES-1, go to WAIT.
- WAIT: cnt decrements each cycle. At cnt==0:
  - if GAP_CYCLES>0, load cnt=GAP_CYCLES-1 and go to GAP;
  - else go to IDLE with busy=0.
- GAP: cnt decrements. At cnt==0, go to IDLE with busy=0.
- Back-to-back latency: a byte still queued launches on the first IDLE cycle's edge. Start pulses are therefore exactly 1+FRAME_CYCLES+GAP_CYCLES+1 cycles apart.
- First-byte latency: write accepted at edge N -> empty=0 after N -> start high after edge N+1.
- p_dat, cpol and cpha are held unchanged through WAIT, GAP and IDLE until the next launch. Changing cfg_* mid-frame has no effect on the current frame.

Flush:
- Clears pointers and count; goes to IDLE; start=0, busy=0.
- p_dat, cpol and cpha keep their last values.
- A wr_en in the same cycle as flush is discarded without ovf.
- Flush has priority over every other event.

Reset mid-frame: all state is cleared immediately and asynchronously; there is no partial-frame recovery.

Test Plan:
1. Reset, write 8'hA5 with cfg_cpol=1, cfg_cpha=0 -> start pulses 1 cycle, one cycle after the write is accepted; p_dat=8'hA5, cpol=1, cpha=0; busy high for 1+40+4 cycles; empty=1 after pop.
2. Burst-write 8'h01..8'h03 on consecutive cycles -> three start pulses spaced 46 cycles apart; p_dat sequence 01, 02, 03; count peaks at 2 (first byte pops the cycle after its write).
3. With the FSM held in WAIT, write 9 bytes into DEPTH=8 -> full=1 after 8 writes; 9th write dropped with ovf=1 for 1 cycle; count=8; bytes drain in order with the 9th never sent.
4. Toggle cfg_cpha 0->1 during WAIT of frame 1 -> cpha stays 0 until frame 2's launch, then 1.
5. Queue 4 bytes, assert flush during WAIT together with wr_en -> count=0, empty=1, busy=0, no further start, no ovf; p_dat still holds the first byte.
6. Drop rst_n mid-GAP -> all outputs immediately at reset values, p_dat=8'h00. After release, a new write launches normally. Repeat scenario 2 with GAP_CYCLES=0 -> start spacing of 42 cycles.

Source files
------------

// File: rtl/spi_tx_feeder.sv
// Byte FIFO plus frame pacer that feeds the start/p_dat/cpol/cpha inputs of the SPI stage.
// Each launch is followed by a fixed frame wait and an optional gap, counted in clk cycles.
module spi_tx_feeder #(
  parameter int DEPTH        = 8,
  parameter int FRAME_CYCLES = 40,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     cfg_cpol,
  input  logic                     cfg_cpha,
  input  logic                     flush,
  output logic                     start,
  output logic [7:0]               p_dat,
  output logic                     cpol,
  output logic                     cpha,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int PW   = $clog2(DEPTH);
  localparam int MAXC = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_acc;
  logic          pop;
  logic [PW:0]   count_next;

  // A write that coincides with flush is discarded, and a full FIFO never
  // accepts a write even when a pop happens in the same cycle.
  always_comb begin
    wr_acc     = wr_en && !full && !flush;
    pop        = (state == IDLE) && !empty && !flush;
    count_next = count;
    if (wr_acc && !pop) begin
      count_next = count + COUNT_ONE;
    end else if (pop && !wr_acc) begin
      count_next = count - COUNT_ONE;
    end
  end

  // Storage is left unreset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      ovf <= wr_en && full && !flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        full   <= 1'b0;
        empty  <= 1'b1;
      end else begin
        if (wr_acc) begin
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
        end
        count <= count_next;
        full  <= (count_next == FULL_COUNT);
        empty <= (count_next == '0);
      end
    end
  end

  // p_dat/cpol/cpha change only on a launch, so flush leaves them holding the last frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      start <= 1'b0;
      busy  <= 1'b0;
      p_dat <= 8'h00;
      cpol  <= 1'b0;
      cpha  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            p_dat <= mem[rd_ptr];
            cpol  <= cfg_cpol;
            cpha  <= cfg_cpha;
            start <= 1'b1;
            busy  <= 1'b1;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          start <= 1'b0;
          cnt   <= FRAME_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (GAP_CYCLES > 0) begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          start <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Scoreboard bench for spi_tx_feeder: stimulus queues expected launches, monitors
// compare every start pulse (byte, polarity, phase, spacing) against the queue.
`timescale 1ns/1ps
module tb_spi_tx_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, wr_en, wr_en2, cfg_cpol, cfg_cpha, flush;
  logic [7:0] wr_data, wr_data2;

  logic       start, cpol, cpha, busy, full, empty, ovf;
  logic [7:0] p_dat;
  logic [3:0] count;
  logic       start2, cpol2, cpha2, busy2, full2, empty2, ovf2;
  logic [7:0] p_dat2;
  logic [3:0] count2;

  spi_tx_feeder #(.DEPTH(8), .FRAME_CYCLES(40), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .flush(flush),
    .start(start), .p_dat(p_dat), .cpol(cpol), .cpha(cpha), .busy(busy),
    .full(full), .empty(empty), .count(count), .ovf(ovf)
  );

  spi_tx_feeder #(.DEPTH(8), .FRAME_CYCLES(40), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data2),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .flush(flush),
    .start(start2), .p_dat(p_dat2), .cpol(cpol2), .cpha(cpha2), .busy(busy2),
    .full(full2), .empty(empty2), .count(count2), .ovf(ovf2)
  );

  typedef struct packed {
    logic [7:0]  dat;
    logic        cpol;
    logic        cpha;
    logic [15:0] gap;   // required cycles since previous start; 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_q2[$];
  exp_t e1, e2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last1 = 0;
  int last2 = 0;
  int peak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect1(input logic [7:0] d, input logic pl, input logic ph, input logic [15:0] g);
    exp_q.push_back('{dat: d, cpol: pl, cpha: ph, gap: g});
  endtask

  task automatic expect2(input logic [7:0] d, input logic pl, input logic ph, input logic [15:0] g);
    exp_q2.push_back('{dat: d, cpol: pl, cpha: ph, gap: g});
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || !empty) && n < bound) begin
      tick(1);
      if (int'(count) > peak) peak = int'(count);
      n++;
    end
    check("idle_timeout", {31'd0, busy || !empty}, 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (start) begin
      if (exp_q.size() == 0) begin
        check("start_unexpected", 32'd1, 32'd0);
      end else begin
        e1 = exp_q.pop_front();
        $display("start  p_dat=%02h cpol=%0d cpha=%0d cycle=%0d", p_dat, cpol, cpha, cyc);
        check("launch_p_dat", {24'd0, p_dat}, {24'd0, e1.dat});
        check("launch_cpol", {31'd0, cpol}, {31'd0, e1.cpol});
        check("launch_cpha", {31'd0, cpha}, {31'd0, e1.cpha});
        if (e1.gap != 0) check("start_spacing", cyc - last1, {16'd0, e1.gap});
      end
      last1 = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (start2) begin
      if (exp_q2.size() == 0) begin
        check("nogap_start_unexpected", 32'd1, 32'd0);
      end else begin
        e2 = exp_q2.pop_front();
        $display("start2 p_dat=%02h cpol=%0d cpha=%0d cycle=%0d", p_dat2, cpol2, cpha2, cyc);
        check("nogap_p_dat", {24'd0, p_dat2}, {24'd0, e2.dat});
        if (e2.gap != 0) check("nogap_spacing", cyc - last2, {16'd0, e2.gap});
      end
      last2 = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_en2 = 1'b0; wr_data = 8'h00; wr_data2 = 8'h00;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; flush = 1'b0;
    tick(3);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_p_dat", {24'd0, p_dat}, 32'd0);
    check("rst_cpol", {31'd0, cpol}, 32'd0);
    check("rst_cpha", {31'd0, cpha}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single byte: launch one cycle after the write, busy for 45 cycles.
    cfg_cpol = 1'b1; cfg_cpha = 1'b0;
    wr_data = 8'hA5; wr_en = 1'b1; expect1(8'hA5, 1'b1, 1'b0, 16'd0);
    tick(1); wr_en = 1'b0;
    check("s1_empty_after_write", {31'd0, empty}, 32'd0);
    check("s1_count_after_write", {28'd0, count}, 32'd1);
    check("s1_start_not_yet", {31'd0, start}, 32'd0);
    tick(1);
    check("s1_start", {31'd0, start}, 32'd1);
    check("s1_busy", {31'd0, busy}, 32'd1);
    check("s1_empty_after_pop", {31'd0, empty}, 32'd1);
    n = 0;
    while (busy && n < 200) begin n++; tick(1); end
    check("s1_busy_cycles", n, 32'd45);
    check("s1_p_dat_held", {24'd0, p_dat}, 32'hA5);
    check("s1_cpol_held", {31'd0, cpol}, 32'd1);

    // Burst of three: spacing 46, occupancy peaks at 2.
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; peak = 0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(i + 1); wr_en = 1'b1;
      expect1(8'(i + 1), 1'b0, 1'b0, (i == 0) ? 16'd0 : 16'd46);
      tick(1);
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    wait_idle(1000);
    check("s2_count_peak", peak, 32'd2);

    // Overflow while the FSM sits in WAIT.
    wr_data = 8'h30; wr_en = 1'b1; expect1(8'h30, 1'b0, 1'b0, 16'd0);
    tick(1); wr_en = 1'b0;
    tick(4);
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'(8'h40 + i); wr_en = 1'b1;
      if (i < 8) expect1(8'(8'h40 + i), 1'b0, 1'b0, 16'd46);
      tick(1);
      if (i == 7) begin
        check("s3_full_after_8", {31'd0, full}, 32'd1);
        check("s3_count_after_8", {28'd0, count}, 32'd8);
        check("s3_no_ovf_before_9th", {31'd0, ovf}, 32'd0);
      end
      if (i == 8) begin
        check("s3_ovf_9th", {31'd0, ovf}, 32'd1);
        check("s3_count_after_9", {28'd0, count}, 32'd8);
      end
    end
    wr_en = 1'b0;
    tick(1);
    check("s3_ovf_one_cycle", {31'd0, ovf}, 32'd0);
    wait_idle(2000);

    // cfg_cpha change mid-frame only takes effect at the next launch.
    wr_data = 8'hC1; wr_en = 1'b1; expect1(8'hC1, 1'b0, 1'b0, 16'd0);
    tick(1);
    wr_data = 8'hC2; expect1(8'hC2, 1'b0, 1'b1, 16'd46);
    tick(1); wr_en = 1'b0;
    tick(6); cfg_cpha = 1'b1;
    tick(2);
    check("s4_cpha_held_mid_frame", {31'd0, cpha}, 32'd0);
    wait_idle(1000);
    check("s4_cpha_frame2", {31'd0, cpha}, 32'd1);
    cfg_cpha = 1'b0;

    // Flush during WAIT together with a write.
    expect1(8'hD1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'hD1 + i); wr_en = 1'b1;
      tick(1);
    end
    wr_en = 1'b0;
    tick(10);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick(1);
    flush = 1'b0; wr_en = 1'b0;
    check("s5_count", {28'd0, count}, 32'd0);
    check("s5_empty", {31'd0, empty}, 32'd1);
    check("s5_busy", {31'd0, busy}, 32'd0);
    check("s5_ovf", {31'd0, ovf}, 32'd0);
    check("s5_p_dat_kept", {24'd0, p_dat}, 32'hD1);
    tick(100);
    check("s5_still_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the gap.
    cfg_cpol = 1'b1; cfg_cpha = 1'b1;
    wr_data = 8'hF1; wr_en = 1'b1; expect1(8'hF1, 1'b1, 1'b1, 16'd0);
    tick(1); wr_en = 1'b0;
    tick(1);
    tick(43);
    check("s6_busy_in_gap", {31'd0, busy}, 32'd1);
    #2; rst_n = 1'b0; #1;
    check("s6_rst_start", {31'd0, start}, 32'd0);
    check("s6_rst_p_dat", {24'd0, p_dat}, 32'd0);
    check("s6_rst_cpol", {31'd0, cpol}, 32'd0);
    check("s6_rst_cpha", {31'd0, cpha}, 32'd0);
    check("s6_rst_busy", {31'd0, busy}, 32'd0);
    check("s6_rst_empty", {31'd0, empty}, 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    wr_data = 8'h5A; wr_en = 1'b1; expect1(8'h5A, 1'b0, 1'b0, 16'd0);
    tick(1); wr_en = 1'b0;
    tick(1);
    check("s6_restart_start", {31'd0, start}, 32'd1);
    wait_idle(1000);

    // No-gap instance: spacing 42.
    for (int i = 0; i < 3; i++) begin
      wr_data2 = 8'(i + 1); wr_en2 = 1'b1;
      expect2(8'(i + 1), 1'b0, 1'b0, (i == 0) ? 16'd0 : 16'd42);
      tick(1);
    end
    wr_en2 = 1'b0;
    n = 0;
    while ((busy2 || !empty2) && n < 1000) begin n++; tick(1); end
    check("nogap_idle_timeout", {31'd0, busy2 || !empty2}, 32'd0);

    tick(2);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp_q2_drained", exp_q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
